// File: rtl/fifo_axis_reader.sv
// Drain side of the UDP filter packet buffer: pops FWFT FIFO words {tlast, tkeep, tdata}
// and presents them on an AXI-Stream master through a 2-entry register skid. In packet
// mode a packet is only released once its commit has been counted.
module fifo_axis_reader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned PACKET_MODE = 1
) (
  input  logic                             clk_i,
  input  logic                             a_rst_i,
  input  logic [DATA_WIDTH+KEEP_WIDTH:0]   fifo_data_i,
  input  logic                             fifo_empty_i,
  output logic                             fifo_rd_en_o,
  input  logic                             pkt_commit_i,
  input  logic                             flush_i,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep_o,
  output logic                             m_axis_tlast_o,
  output logic                             m_axis_tvalid_o,
  input  logic                             m_axis_tready_i,
  output logic [CNT_WIDTH-1:0]             pkt_cnt_o,
  output logic                             busy_o,
  output logic                             credit_ovf_o
);

  localparam int unsigned WordWidth = DATA_WIDTH + KEEP_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

  state_e               state_q;
  logic [WordWidth-1:0] buf0_q;
  logic [WordWidth-1:0] buf1_q;
  logic [1:0]           buf_cnt_q;
  logic [CNT_WIDTH-1:0] pkt_cnt_q;
  logic [CNT_WIDTH-1:0] pkt_cnt_d;
  logic                 ovf_q;
  logic                 ovf_d;

  logic pop;
  logic push;
  logic fire;
  logic word_last;
  logic last_pop;
  logic credit_ok;

  assign word_last = fifo_data_i[WordWidth-1];
  assign credit_ok = (PACKET_MODE == 0) || (pkt_cnt_q != '0);
  assign fire      = (buf_cnt_q != 2'd0) && m_axis_tready_i;
  // Only STREAM feeds the skid; FLUSH pops are dropped on the floor.
  assign push      = pop && (state_q == StStream);
  assign last_pop  = pop && word_last;

  // Pop decision depends only on registered state and FIFO status, never on tready.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      StStream: pop = !fifo_empty_i && (buf_cnt_q < 2'd2);
      StFlush:  pop = !fifo_empty_i;
      default:  pop = 1'b0;
    endcase
  end

  // Credit counter next state: saturates at all-ones, never wraps below zero.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    ovf_d     = ovf_q;
    if (pkt_commit_i && !last_pop) begin
      if (pkt_cnt_q == {CNT_WIDTH{1'b1}}) begin
        ovf_d = 1'b1;
      end else begin
        pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
    end else if (last_pop && !pkt_commit_i && (pkt_cnt_q != '0)) begin
      pkt_cnt_d = pkt_cnt_q - 1'b1;
    end
  end

  // Credit counter and sticky overflow registers.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      pkt_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Read FSM: flush wins over stream in IDLE; a started packet always runs to its tlast.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_i && credit_ok && (buf_cnt_q == 2'd0)) begin
            state_q <= StFlush;
          end else if (!fifo_empty_i && credit_ok) begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (last_pop && (PACKET_MODE != 0) && (pkt_cnt_d == '0)) begin
            state_q <= StIdle;
          end
        end
        StFlush: begin
          if (last_pop) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Two-entry skid; buf0 is always the oldest entry and drives the stream outputs.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      buf0_q    <= '0;
      buf1_q    <= '0;
      buf_cnt_q <= 2'd0;
    end else begin
      if (buf_cnt_q == 2'd0) begin
        if (push) begin
          buf0_q    <= fifo_data_i;
          buf_cnt_q <= 2'd1;
        end
      end else if (buf_cnt_q == 2'd1) begin
        if (fire && push) begin
          buf0_q <= fifo_data_i;
        end else if (fire) begin
          buf_cnt_q <= 2'd0;
        end else if (push) begin
          buf1_q    <= fifo_data_i;
          buf_cnt_q <= 2'd2;
        end
      end else begin
        // Full: no push is possible, only drain.
        if (fire) begin
          buf0_q    <= buf1_q;
          buf_cnt_q <= 2'd1;
        end
      end
    end
  end

  assign fifo_rd_en_o    = pop;
  assign m_axis_tdata_o  = buf0_q[DATA_WIDTH-1:0];
  assign m_axis_tkeep_o  = buf0_q[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast_o  = buf0_q[WordWidth-1];
  assign m_axis_tvalid_o = (buf_cnt_q != 2'd0);
  assign pkt_cnt_o       = pkt_cnt_q;
  assign busy_o          = (state_q != StIdle) || (buf_cnt_q != 2'd0);
  assign credit_ovf_o    = ovf_q;

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench: dut1 is packet mode with a 2-bit credit counter, dut0 is stream mode.
// Each DUT has a small queue-based FWFT FIFO model driven from the single stimulus process.
module tb_fifo_axis_reader;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int WW = DW + KW + 1;

  logic clk = 1'b0;
  logic rst;

  logic [WW-1:0] fdata1, fdata0;
  logic          fempty1, fempty0;
  logic          rd1, rd0;
  logic          commit1, commit0;
  logic          flush1, flush0;
  logic [DW-1:0] tdata1, tdata0;
  logic [KW-1:0] tkeep1, tkeep0;
  logic          tlast1, tlast0;
  logic          tvalid1, tvalid0;
  logic          tready1, tready0;
  logic [1:0]    cnt1;
  logic [7:0]    cnt0;
  logic          busy1, busy0;
  logic          ovf1, ovf0;

  logic [WW-1:0] q1[$];
  logic [WW-1:0] q0[$];
  logic [WW-1:0] got1[$];
  logic [WW-1:0] got0[$];

  int checks = 0;
  int errors = 0;
  int pops1  = 0;
  int base;

  always #5 clk = ~clk;

  fifo_axis_reader #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .CNT_WIDTH  (2),
    .PACKET_MODE(1)
  ) dut1 (
    .clk_i          (clk),
    .a_rst_i        (rst),
    .fifo_data_i    (fdata1),
    .fifo_empty_i   (fempty1),
    .fifo_rd_en_o   (rd1),
    .pkt_commit_i   (commit1),
    .flush_i        (flush1),
    .m_axis_tdata_o (tdata1),
    .m_axis_tkeep_o (tkeep1),
    .m_axis_tlast_o (tlast1),
    .m_axis_tvalid_o(tvalid1),
    .m_axis_tready_i(tready1),
    .pkt_cnt_o      (cnt1),
    .busy_o         (busy1),
    .credit_ovf_o   (ovf1)
  );

  fifo_axis_reader #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .CNT_WIDTH  (8),
    .PACKET_MODE(0)
  ) dut0 (
    .clk_i          (clk),
    .a_rst_i        (rst),
    .fifo_data_i    (fdata0),
    .fifo_empty_i   (fempty0),
    .fifo_rd_en_o   (rd0),
    .pkt_commit_i   (commit0),
    .flush_i        (flush0),
    .m_axis_tdata_o (tdata0),
    .m_axis_tkeep_o (tkeep0),
    .m_axis_tlast_o (tlast0),
    .m_axis_tvalid_o(tvalid0),
    .m_axis_tready_i(tready0),
    .pkt_cnt_o      (cnt0),
    .busy_o         (busy0),
    .credit_ovf_o   (ovf0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fempty1 = (q1.size() == 0);
    fdata1  = (q1.size() == 0) ? '0 : q1[0];
    fempty0 = (q0.size() == 0);
    fdata0  = (q0.size() == 0) ? '0 : q0[0];
  endtask

  task automatic push1(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last);
    q1.push_back({last, k, d});
    refresh();
  endtask

  task automatic push0(input logic [DW-1:0] d, input logic last);
    q0.push_back({last, 4'hF, d});
    refresh();
  endtask

  // One clock: sample pops and beats just before the edge, update FIFO models after it.
  task automatic step();
    logic p1, p0;
    #1;
    p1 = rd1;
    p0 = rd0;
    if (tvalid1 && tready1) got1.push_back({tlast1, tkeep1, tdata1});
    if (tvalid0 && tready0) got0.push_back({tlast0, tkeep0, tdata0});
    if (p1) pops1++;
    @(posedge clk);
    #1;
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    refresh();
  endtask

  initial begin
    rst = 1'b1;
    commit1 = 1'b0; commit0 = 1'b0;
    flush1 = 1'b0;  flush0 = 1'b0;
    tready1 = 1'b1; tready0 = 1'b1;
    refresh();
    step(); step();

    // Reset state
    check("rst_tvalid", 64'(tvalid1), 64'd0);
    check("rst_rd_en", 64'(rd1), 64'd0);
    check("rst_cnt", 64'(cnt1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_ovf", 64'(ovf1), 64'd0);
    rst = 1'b0;
    step();

    // Packet mode: uncommitted packet stays put
    push1(32'h0, 4'hF, 1'b0);
    push1(32'h1, 4'hF, 1'b0);
    push1(32'h2, 4'hF, 1'b0);
    push1(32'h3, 4'h3, 1'b1);
    for (int i = 0; i < 20; i++) step();
    check("nocommit_pops", 64'(pops1), 64'd0);
    check("nocommit_tvalid", 64'(tvalid1), 64'd0);

    // Commit at C -> count at C+1 -> tvalid at C+3
    commit1 = 1'b1;
    step();
    commit1 = 1'b0;
    check("commit_cnt", 64'(cnt1), 64'd1);
    check("commit_tvalid_c1", 64'(tvalid1), 64'd0);
    step();
    check("commit_tvalid_c2", 64'(tvalid1), 64'd0);
    step();
    check("beat0_valid", 64'(tvalid1), 64'd1);
    check("beat0_data", 64'(tdata1), 64'h0);
    step();
    check("beat1_data", 64'(tdata1), 64'h1);
    step();
    check("beat2_data", 64'(tdata1), 64'h2);
    check("beat2_last", 64'(tlast1), 64'd0);
    step();
    check("beat3_data", 64'(tdata1), 64'h3);
    check("beat3_last", 64'(tlast1), 64'd1);
    check("beat3_keep", 64'(tkeep1), 64'h3);
    check("pkt_done_cnt", 64'(cnt1), 64'd0);
    step();
    check("pkt_done_tvalid", 64'(tvalid1), 64'd0);
    check("pkt_done_busy", 64'(busy1), 64'd0);

    // Backpressure mid-packet
    got1.delete();
    for (int i = 0; i < 8; i++) push1(DW'(i), 4'hF, (i == 7));
    commit1 = 1'b1;
    step();
    commit1 = 1'b0;
    step(); step(); step();
    tready1 = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("bp_rd_en", 64'(rd1), 64'd0);
    check("bp_tvalid", 64'(tvalid1), 64'd1);
    check("bp_hold_data", 64'(tdata1), 64'h1);
    tready1 = 1'b1;
    for (int i = 0; i < 30 && got1.size() < 8; i++) step();
    check("bp_beats", 64'(got1.size()), 64'd8);
    for (int i = 0; i < 8 && i < got1.size(); i++) check("bp_seq", 64'(got1[i][DW-1:0]), 64'(i));
    if (got1.size() >= 8) check("bp_last", 64'(got1[7][WW-1]), 64'd1);
    step(); step();
    check("bp_cnt", 64'(cnt1), 64'd0);
    check("bp_busy", 64'(busy1), 64'd0);

    // Flush head packet A, then stream B
    got1.delete();
    push1(32'hA0, 4'hF, 1'b0);
    push1(32'hA1, 4'hF, 1'b0);
    push1(32'hA2, 4'hF, 1'b1);
    push1(32'hB0, 4'hF, 1'b0);
    push1(32'hB1, 4'hF, 1'b1);
    commit1 = 1'b1;
    flush1 = 1'b1;
    step(); step();
    commit1 = 1'b0;
    flush1 = 1'b0;
    base = pops1;
    check("flush_cnt2", 64'(cnt1), 64'd2);
    check("flush_busy", 64'(busy1), 64'd1);
    step(); step(); step();
    check("flush_pops", 64'(pops1 - base), 64'd3);
    check("flush_no_beats", 64'(got1.size()), 64'd0);
    check("flush_cnt1", 64'(cnt1), 64'd1);
    for (int i = 0; i < 20 && got1.size() < 2; i++) step();
    check("flush_b_beats", 64'(got1.size()), 64'd2);
    if (got1.size() >= 2) begin
      check("flush_b0", 64'(got1[0]), 64'({1'b0, 4'hF, 32'hB0}));
      check("flush_b1", 64'(got1[1]), 64'({1'b1, 4'hF, 32'hB1}));
    end
    step(); step();
    check("flush_cnt0", 64'(cnt1), 64'd0);

    // Saturation of the 2-bit credit counter
    commit1 = 1'b1;
    step(); step(); step();
    check("sat_cnt3", 64'(cnt1), 64'd3);
    check("sat_ovf_pre", 64'(ovf1), 64'd0);
    step();
    commit1 = 1'b0;
    check("sat_cnt_hold", 64'(cnt1), 64'd3);
    check("sat_ovf", 64'(ovf1), 64'd1);
    step(); step();
    check("sat_ovf_sticky", 64'(ovf1), 64'd1);

    // Commit together with a tlast pop leaves the count unchanged
    got1.delete();
    push1(32'hC0, 4'hF, 1'b1);
    step();
    check("simul_rd_en", 64'(rd1), 64'd1);
    commit1 = 1'b1;
    step();
    commit1 = 1'b0;
    check("simul_cnt", 64'(cnt1), 64'd3);
    step();
    check("simul_beat", 64'(got1.size()), 64'd1);

    // Asynchronous reset with two beats buffered
    tready1 = 1'b0;
    push1(32'hD0, 4'hF, 1'b0);
    push1(32'hD1, 4'hF, 1'b0);
    push1(32'hD2, 4'hF, 1'b1);
    step(); step(); step();
    check("pre_rst_full", 64'(rd1), 64'd0);
    check("pre_rst_data", 64'(tdata1), 64'hD0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tvalid", 64'(tvalid1), 64'd0);
    check("arst_tdata", 64'(tdata1), 64'd0);
    check("arst_cnt", 64'(cnt1), 64'd0);
    check("arst_busy", 64'(busy1), 64'd0);
    check("arst_ovf", 64'(ovf1), 64'd0);
    check("arst_rd_en", 64'(rd1), 64'd0);
    q1.delete();
    refresh();
    step();
    rst = 1'b0;
    tready1 = 1'b1;
    step();

    // Stream mode: underrun mid-packet
    got0.delete();
    push0(32'h10, 1'b0);
    push0(32'h11, 1'b0);
    step(); step();
    check("pm0_beat0", 64'(tdata0), 64'h10);
    check("pm0_valid0", 64'(tvalid0), 64'd1);
    step();
    check("pm0_beat1", 64'(tdata0), 64'h11);
    step();
    check("pm0_gap_valid", 64'(tvalid0), 64'd0);
    check("pm0_gap_busy", 64'(busy0), 64'd1);
    step(); step();
    check("pm0_gap_valid2", 64'(tvalid0), 64'd0);
    push0(32'h12, 1'b0);
    push0(32'h13, 1'b1);
    step();
    check("pm0_resume_valid", 64'(tvalid0), 64'd1);
    check("pm0_resume_data", 64'(tdata0), 64'h12);
    step();
    check("pm0_last_data", 64'(tdata0), 64'h13);
    check("pm0_last_flag", 64'(tlast0), 64'd1);
    step(); step();
    check("pm0_beats", 64'(got0.size()), 64'd4);
    for (int i = 0; i < 4 && i < got0.size(); i++)
      check("pm0_seq", 64'(got0[i][DW-1:0]), 64'(32'h10 + i));
    check("pm0_cnt", 64'(cnt0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
